// File: rtl/game_countdown_timer.sv
// Game-time countdown feeding whack_a_mole_fsm: divides clk into 1 ms ticks and counts GAME_TIME_MS down to 0.
// Optional pause support is enabled by defining GAME_COUNTDOWN_PAUSE_EN.
module game_countdown_timer #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int GAME_TIME_MS = 30000,
  parameter int MAX_TIMER_MS = 30000,
  parameter int TMW          = $clog2(MAX_TIMER_MS + 1),
  parameter int PSW          = $clog2(CLKS_PER_MS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_button_pressed,
  input  logic           reset_button_pressed,
`ifdef GAME_COUNTDOWN_PAUSE_EN
  input  logic           pause_button_pressed,
`endif
  output logic [TMW-1:0] timer_milliseconds,
  output logic           ms_tick,
  output logic           timer_expired,
  output logic           running
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
`ifdef GAME_COUNTDOWN_PAUSE_EN
    ,
    PAUSED  = 2'd3
`endif
  } state_t;

  // An out-of-range GAME_TIME_MS is clamped so the counter can never exceed MAX_TIMER_MS.
  localparam int             LOAD_MS  = (GAME_TIME_MS > MAX_TIMER_MS) ? MAX_TIMER_MS : GAME_TIME_MS;
  localparam logic [TMW-1:0] LOAD_VAL = TMW'(LOAD_MS);
  localparam logic [PSW-1:0] PS_LAST  = PSW'(CLKS_PER_MS - 1);
  localparam logic [TMW-1:0] TMR_ONE  = TMW'(1);

  state_t         state;
  state_t         state_d;
  logic [PSW-1:0] prescaler;
  logic [PSW-1:0] prescaler_d;
  logic [TMW-1:0] timer_d;
  logic           tick_d;
  logic           expired_d;
  logic           running_d;
  logic           tick_due;
  logic           pause_toggle;

`ifdef GAME_COUNTDOWN_PAUSE_EN
  assign pause_toggle = pause_button_pressed &&
                        ((state == RUNNING) || (state == PAUSED));
`else
  assign pause_toggle = 1'b0;
`endif

  assign tick_due = (state == RUNNING) && (prescaler == PS_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    if (reset_button_pressed) begin
      state_d = IDLE;
    end else if (start_button_pressed) begin
      state_d = RUNNING;
    end else if (pause_toggle) begin
`ifdef GAME_COUNTDOWN_PAUSE_EN
      state_d = (state == RUNNING) ? PAUSED : RUNNING;
`endif
    end else if (tick_due && (timer_milliseconds <= TMR_ONE)) begin
      state_d = EXPIRED;
    end
  end

  // Next values for the registered outputs; a pause toggle freezes the prescaler on that edge.
  always_comb begin
    timer_d     = timer_milliseconds;
    prescaler_d = prescaler;
    tick_d      = 1'b0;
    expired_d   = 1'b0;
    running_d   = (state_d == RUNNING);
    if (reset_button_pressed) begin
      timer_d     = '0;
      prescaler_d = '0;
    end else if (start_button_pressed) begin
      timer_d     = LOAD_VAL;
      prescaler_d = '0;
    end else if (!pause_toggle) begin
      case (state)
        RUNNING: begin
          if (tick_due) begin
            prescaler_d = '0;
            tick_d      = 1'b1;
            if (timer_milliseconds != '0) begin
              timer_d = timer_milliseconds - TMR_ONE;
            end
            expired_d = (timer_milliseconds <= TMR_ONE);
          end else begin
            prescaler_d = prescaler + PSW'(1);
          end
        end
`ifdef GAME_COUNTDOWN_PAUSE_EN
        PAUSED: begin
          timer_d     = timer_milliseconds;
          prescaler_d = prescaler;
        end
`endif
        default: begin
          timer_d     = '0;
          prescaler_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_milliseconds <= '0;
      prescaler          <= '0;
      ms_tick            <= 1'b0;
      timer_expired      <= 1'b0;
      running            <= 1'b0;
    end else begin
      timer_milliseconds <= timer_d;
      prescaler          <= prescaler_d;
      ms_tick            <= tick_d;
      timer_expired      <= expired_d;
      running            <= running_d;
    end
  end

endmodule
